pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It drives the stall and bubble controls of the PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB registers from four sources: cache-miss stalls, load-use hazards, branch redirects and multi-cycle divides. It owns two FSMs and two performance counters:
- A redirect-pending FSM, which defers a branch redirect that resolves during an I-cache miss.
- A divide sequencer, which holds EXE for a fixed latency.

Parameters:
DIV_LAT, 4, divider latency in cycles; legal range 1..63.
CNT_W, 6, width of the divide down-counter.
PERF_W, 32, width of the performance counters.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
ic_stall_i  in  1  L1I miss; no valid fetch this cycle
dc_stall_i  in  1  L1D busy; freezes the whole pipeline
id_rs1_i  in  5  ID source register 1
id_rs2_i  in  5  ID source register 2
id_use_rs1_i  in  1  ID instruction reads rs1
id_use_rs2_i  in  1  ID instruction reads rs2
exe_rd_i  in  5  EXE destination register
exe_mem_read_i  in  1  EXE instruction is a load
exe_div_i  in  1  EXE instruction is a div/rem
exe_branch_taken_i  in  1  EXE resolved a taken branch or jump
exe_branch_target_i  in  32  redirect target
pc_stall_o  out  1  hold PC
pc_redirect_o  out  1  PC loads pc_target_o this cycle
pc_target_o  out  32  redirect target
id_stall_o / id_bubble_o  out  1 / 1  IF_ID controls
exe_stall_o / exe_bubble_o  out  1 / 1  ID_EXE controls
mem_stall_o / mem_bubble_o  out  1 / 1  EXE_MEM controls
wb_bubble_o  out  1  MEM_WB inserts NOP
div_done_o  out  1  divide result valid in EXE
stall_cnt_o  out  PERF_W  cycles with pc_stall_o=1
flush_cnt_o  out  PERF_W  accepted branch flushes

Behaviour:
- Control outputs are combinational from state and inputs. State is: redir_state (R_IDLE, R_PEND), tgt_q[31:0], div_state (D_IDLE, D_BUSY, D_DONE), cnt_q, and the two performance counters.
- Reset: all FSMs go to IDLE; tgt_q, cnt_q and both counters go to 0. With reset asserted, div_done_o=0 and pc_redirect_o=0.
- Reset mid-divide or mid-pend aborts to IDLE with no pulse.
- Per stage, stall and bubble are never asserted together.
- Derived terms:
  - lu = exe_mem_read_i & exe_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==exe_rd_i) | (id_use_rs2_i & id_rs2_i==exe_rd_i)).
  - div_stall = (D_IDLE & exe_div_i) | D_BUSY.
- Priority, highest first:
  1. dc_stall_i: pc/id/exe/mem stall=1, wb_bubble=1. No redirect. Branch and load-use are ignored because EXE re-presents them later.
  2. div_stall: pc/id/exe stall=1, mem_bubble=1.
  3. exe_branch_taken_i: id_bubble=1 and exe_bubble=1; flush_cnt increments.
     - If R_IDLE and !ic_stall_i: pc_redirect_o=1, pc_target_o=exe_branch_target_i.
     - If ic_stall_i: pc_stall=1, tgt_q<=target, go to R_PEND.
  4. lu: pc_stall=1, id_stall=1, exe_bubble=1 (one cycle; the bubble clears the hazard).
  5. ic_stall_i: pc_stall=1, id_bubble=1.
- R_PEND:
  - While ic_stall_i: pc_stall=1, id_bubble=1.
  - On the first cycle with !ic_stall_i & !dc_stall_i: id_bubble=1 (squashes the wrong-path fetch), pc_redirect_o=1, pc_target_o=tgt_q, go to R_IDLE.
  - No new branch can arrive in R_PEND because ID and EXE hold bubbles.
- Divide FSM (advances regardless of dc_stall_i):
  - D_IDLE & exe_div_i: cnt_q<=DIV_LAT-1, go to D_BUSY.
  - D_BUSY: if cnt_q==0 go to D_DONE, else decrement cnt_q.
  - D_DONE: div_done_o=1, no div stall; go to D_IDLE when !dc_stall_i (EXE advances).
  - Result: EXE is held DIV_LAT+1 cycles, and div_done_o rises DIV_LAT+1 cycles after the issue cycle.
- Counters wrap at 2^PERF_W. stall_cnt_o counts every cycle pc_stall_o=1, including during freeze.

Decomposition:
- Shared package cpu_ctrl_pkg holds redir_state_e, div_state_e and the x0 register index constant.
- One sub-module, div_sequencer, contains the divide FSM, cnt_q and div_done_o. It exports div_stall.

Test Plan:
1. Load-use: EXE lw x5, ID add using x5 as rs1 -> one cycle of pc_stall=1, id_stall=1, exe_bubble=1, then no stall. Same case with exe_rd_i=0 -> no stall.
2. Branch without miss: exe_branch_taken_i=1, target 0x0000_0100 -> same-cycle pc_redirect_o=1, pc_target_o=0x100, id_bubble=exe_bubble=1, flush_cnt_o 0->1.
3. Branch during I-miss: taken to 0x200 with ic_stall_i held 3 more cycles -> pc_redirect_o=0 for 3 cycles with id_bubble=1. On the cycle ic_stall_i drops: pc_redirect_o=1, pc_target_o=0x200, id_bubble=1, then R_IDLE.
4. Divide, DIV_LAT=4: exe_div_i at cycle 0 -> exe_stall=1 and mem_bubble=1 in cycles 0-4, div_done_o=1 in cycle 5 with no stall.
5. Divide completing under dc_stall_i (cycles 4-6) -> D_DONE and div_done_o held until dc_stall_i drops. wb_bubble=1 throughout, stall_cnt_o counts every stalled cycle.
6. Async reset asserted mid-divide and in R_PEND -> immediately div_done_o=0, pc_redirect_o=0, counters 0. After release: no redirect and no divide done without new stimulus.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encodings and register constants.
package cpu_ctrl_pkg;

  typedef enum logic {
    RIdle,
    RPend
  } redir_state_e;

  typedef enum logic [1:0] {
    DIdle,
    DBusy,
    DDone
  } div_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/div_sequencer.sv
// Divide sequencer: holds EXE for DIV_LAT+1 cycles, then presents div_done until EXE advances.
module div_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic exe_div_i,
  input  logic dc_stall_i,
  output logic div_stall_o,
  output logic div_done_o
);

  div_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= DIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    div_stall_o  = 1'b0;
    div_done_o   = 1'b0;
    unique case (r_state)
      DIdle: begin
        if (exe_div_i) begin
          div_stall_o  = 1'b1;
          w_cnt_next   = CNT_W'(DIV_LAT - 1);
          w_state_next = DBusy;
        end
      end
      DBusy: begin
        div_stall_o = 1'b1;
        if (r_cnt == '0) w_state_next = DDone;
        else             w_cnt_next   = r_cnt - CNT_W'(1);
      end
      DDone: begin
        div_done_o = 1'b1;
        // Result must stay visible while a D-cache freeze keeps EXE in place.
        if (!dc_stall_i) w_state_next = DIdle;
      end
      default: w_state_next = DIdle;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: stall/bubble arbitration, deferred redirects
// across I-cache misses, divide holds and performance counters.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_stall_i,
  input  logic              dc_stall_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [4:0]        exe_rd_i,
  input  logic              exe_mem_read_i,
  input  logic              exe_div_i,
  input  logic              exe_branch_taken_i,
  input  logic [31:0]       exe_branch_target_i,
  output logic              pc_stall_o,
  output logic              pc_redirect_o,
  output logic [31:0]       pc_target_o,
  output logic              id_stall_o,
  output logic              id_bubble_o,
  output logic              exe_stall_o,
  output logic              exe_bubble_o,
  output logic              mem_stall_o,
  output logic              mem_bubble_o,
  output logic              wb_bubble_o,
  output logic              div_done_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  redir_state_e      r_redir_state, w_redir_next;
  logic [31:0]       r_tgt, w_tgt_next;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;
  logic              w_lu, w_div_stall, w_redirect, w_flush_inc;

  div_sequencer #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_sequencer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .exe_div_i   (exe_div_i),
    .dc_stall_i  (dc_stall_i),
    .div_stall_o (w_div_stall),
    .div_done_o  (div_done_o)
  );

  assign w_lu = exe_mem_read_i && (exe_rd_i != REG_X0) &&
                ((id_use_rs1_i && (id_rs1_i == exe_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == exe_rd_i)));

  always_comb begin
    pc_stall_o   = 1'b0;
    w_redirect   = 1'b0;
    pc_target_o  = exe_branch_target_i;
    id_stall_o   = 1'b0;
    id_bubble_o  = 1'b0;
    exe_stall_o  = 1'b0;
    exe_bubble_o = 1'b0;
    mem_stall_o  = 1'b0;
    mem_bubble_o = 1'b0;
    wb_bubble_o  = 1'b0;
    w_flush_inc  = 1'b0;
    w_redir_next = r_redir_state;
    w_tgt_next   = r_tgt;
    if (dc_stall_i) begin
      pc_stall_o  = 1'b1;
      id_stall_o  = 1'b1;
      exe_stall_o = 1'b1;
      mem_stall_o = 1'b1;
      wb_bubble_o = 1'b1;
    end else if (w_div_stall) begin
      pc_stall_o   = 1'b1;
      id_stall_o   = 1'b1;
      exe_stall_o  = 1'b1;
      mem_bubble_o = 1'b1;
    end else if (r_redir_state == RPend) begin
      // Whatever is fetched while pending is wrong-path, so ID always takes a bubble.
      id_bubble_o = 1'b1;
      if (ic_stall_i) begin
        pc_stall_o = 1'b1;
      end else begin
        w_redirect   = 1'b1;
        pc_target_o  = r_tgt;
        w_redir_next = RIdle;
      end
    end else if (exe_branch_taken_i) begin
      id_bubble_o  = 1'b1;
      exe_bubble_o = 1'b1;
      w_flush_inc  = 1'b1;
      if (ic_stall_i) begin
        pc_stall_o   = 1'b1;
        w_tgt_next   = exe_branch_target_i;
        w_redir_next = RPend;
      end else begin
        w_redirect = 1'b1;
      end
    end else if (w_lu) begin
      pc_stall_o   = 1'b1;
      id_stall_o   = 1'b1;
      exe_bubble_o = 1'b1;
    end else if (ic_stall_i) begin
      pc_stall_o  = 1'b1;
      id_bubble_o = 1'b1;
    end
  end

  assign pc_redirect_o = w_redirect & ~rst_i;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_redir_state <= RIdle;
      r_tgt         <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_redir_state <= w_redir_next;
      r_tgt         <= w_tgt_next;
      if (pc_stall_o)  r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table of priority vectors plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic        clk, rst;
  logic        ic_stall, dc_stall;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, mem_read, div, br;
  logic [31:0] br_tgt;
  logic        pc_stall, pc_redirect, id_stall, id_bubble, exe_stall, exe_bubble;
  logic        mem_stall, mem_bubble, wb_bubble, div_done;
  logic [31:0] pc_target, stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(
    .DIV_LAT (4),
    .CNT_W   (6),
    .PERF_W  (32)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .ic_stall_i          (ic_stall),
    .dc_stall_i          (dc_stall),
    .id_rs1_i            (rs1),
    .id_rs2_i            (rs2),
    .id_use_rs1_i        (use1),
    .id_use_rs2_i        (use2),
    .exe_rd_i            (rd),
    .exe_mem_read_i      (mem_read),
    .exe_div_i           (div),
    .exe_branch_taken_i  (br),
    .exe_branch_target_i (br_tgt),
    .pc_stall_o          (pc_stall),
    .pc_redirect_o       (pc_redirect),
    .pc_target_o         (pc_target),
    .id_stall_o          (id_stall),
    .id_bubble_o         (id_bubble),
    .exe_stall_o         (exe_stall),
    .exe_bubble_o        (exe_bubble),
    .mem_stall_o         (mem_stall),
    .mem_bubble_o        (mem_bubble),
    .wb_bubble_o         (wb_bubble),
    .div_done_o          (div_done),
    .stall_cnt_o         (stall_cnt),
    .flush_cnt_o         (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pc_stall, redirect, id_stall, id_bubble, exe_stall, exe_bubble,
  // mem_stall, mem_bubble, wb_bubble, div_done.
  logic [9:0] ctl;
  assign ctl = {pc_stall, pc_redirect, id_stall, id_bubble, exe_stall, exe_bubble,
                mem_stall, mem_bubble, wb_bubble, div_done};

  localparam logic [9:0] C_NONE = 10'h000;
  localparam logic [9:0] C_LU   = 10'h290;
  localparam logic [9:0] C_BR   = 10'h150;
  localparam logic [9:0] C_BRIC = 10'h250;
  localparam logic [9:0] C_IC   = 10'h240;
  localparam logic [9:0] C_DC   = 10'h2AA;
  localparam logic [9:0] C_DIV  = 10'h2A4;
  localparam logic [9:0] C_DONE = 10'h001;
  localparam logic [9:0] C_REDR = 10'h140;

  typedef struct {
    logic       ic, dc;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       mr, dv, br;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ic_stall = 0; dc_stall = 0; rs1 = 0; rs2 = 0; use1 = 0; use2 = 0;
    rd = 0; mem_read = 0; div = 0; br = 0; br_tgt = 32'h0000_0100;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Advance to the next cycle's input window (just after the falling edge).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    //           ic  dc  rs1    rs2    u1  u2  rd     mr  dv  br  exp
    tbl[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE};
    tbl[1]  = '{1'b0, 1'b0, 5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_LU};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, C_NONE};
    tbl[3]  = '{1'b0, 1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, C_LU};
    tbl[4]  = '{1'b0, 1'b0, 5'd5, 5'd1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_NONE};
    tbl[5]  = '{1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NONE};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_BR};
    tbl[7]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, C_BRIC};
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_IC};
    tbl[9]  = '{1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DC};
    tbl[10] = '{1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, C_DC};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_DIV};
    tbl[12] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DIV};
    tbl[13] = '{1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, C_LU};
    tbl[14] = '{1'b0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, C_BR};

    // Reset state
    #2;
    check("reset_ctl", 32'(ctl), 32'(C_NONE));
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational priority vectors, each from a fresh idle state
    for (int i = 0; i < 15; i++) begin
      do_reset();
      ic_stall = tbl[i].ic; dc_stall = tbl[i].dc; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      use1 = tbl[i].u1; use2 = tbl[i].u2; rd = tbl[i].rd; mem_read = tbl[i].mr;
      div = tbl[i].dv; br = tbl[i].br;
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].exp));
    end

    // Load-use lasts one cycle: bubble in EXE clears it
    do_reset();
    mem_read = 1; rd = 5'd5; rs1 = 5'd5; use1 = 1; #1;
    check("lu_cycle0", 32'(ctl), 32'(C_LU));
    next_cycle();
    mem_read = 0; rd = 5'd0; #1;
    check("lu_cycle1", 32'(ctl), 32'(C_NONE));

    // Branch without miss
    do_reset();
    br = 1; br_tgt = 32'h0000_0100; #1;
    check("br_ctl", 32'(ctl), 32'(C_BR));
    check("br_target", pc_target, 32'h0000_0100);
    check("br_flush_before", flush_cnt, 32'd0);
    next_cycle();
    br = 0; #1;
    check("br_flush_after", flush_cnt, 32'd1);

    // Branch during I-miss, redirect deferred
    do_reset();
    br = 1; ic_stall = 1; br_tgt = 32'h0000_0200; #1;
    check("pend_c0", 32'(ctl), 32'(C_BRIC));
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      br = 0; br_tgt = 32'hDEAD_BEEF; #1;
      check($sformatf("pend_c%0d", c), 32'(ctl), 32'(C_IC));
    end
    next_cycle();
    ic_stall = 0; #1;
    check("pend_release_ctl", 32'(ctl), 32'(C_REDR));
    check("pend_release_tgt", pc_target, 32'h0000_0200);
    next_cycle();
    #1;
    check("pend_idle_ctl", 32'(ctl), 32'(C_NONE));
    check("pend_stall_cnt", stall_cnt, 32'd4);
    check("pend_flush_cnt", flush_cnt, 32'd1);

    // Divide, latency 4
    do_reset();
    div = 1;
    for (int c = 0; c <= 4; c++) begin
      #1;
      check($sformatf("div_c%0d", c), 32'(ctl), 32'(C_DIV));
      next_cycle();
    end
    #1;
    check("div_done_c5", 32'(ctl), 32'(C_DONE));
    next_cycle();
    div = 0; #1;
    check("div_idle_c6", 32'(ctl), 32'(C_NONE));
    check("div_stall_cnt", stall_cnt, 32'd5);

    // Divide completing under D-cache freeze in cycles 4-6
    do_reset();
    div = 1;
    for (int c = 0; c <= 3; c++) begin
      #1;
      check($sformatf("divdc_c%0d", c), 32'(ctl), 32'(C_DIV));
      next_cycle();
    end
    dc_stall = 1; #1;
    check("divdc_c4", 32'(ctl), 32'(C_DC));
    for (int c = 5; c <= 6; c++) begin
      next_cycle();
      #1;
      check($sformatf("divdc_c%0d", c), 32'(ctl), 32'(C_DC | C_DONE));
    end
    next_cycle();
    dc_stall = 0; #1;
    check("divdc_c7", 32'(ctl), 32'(C_DONE));
    next_cycle();
    div = 0; #1;
    check("divdc_c8", 32'(ctl), 32'(C_NONE));
    check("divdc_stall_cnt", stall_cnt, 32'd7);

    // Async reset mid-divide
    do_reset();
    div = 1;
    next_cycle();
    next_cycle();
    #1;
    rst = 1; #1;
    check("rst_div_ctl", 32'(ctl), 32'(C_DIV));
    check("rst_div_cnt", stall_cnt, 32'd0);
    div = 0; #1;
    check("rst_div_quiet", 32'(ctl), 32'(C_NONE));
    next_cycle();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("rst_div_post%0d", c), 32'(ctl), 32'(C_NONE));
      next_cycle();
    end

    // Async reset while a redirect is pending
    do_reset();
    br = 1; ic_stall = 1; br_tgt = 32'h0000_0300;
    next_cycle();
    br = 0; #1;
    check("rst_pend_before", 32'(ctl), 32'(C_IC));
    ic_stall = 0; br = 1; rst = 1; #1;
    check("rst_pend_redirect", 32'(pc_redirect), 32'd0);
    check("rst_pend_flush", flush_cnt, 32'd0);
    br = 0;
    next_cycle();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rst_pend_post%0d", c), 32'(ctl), 32'(C_NONE));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
